// File: rtl/pwm_bank_pkg.sv
// Shared constants and types for the PWM bank: register map, mode bits and
// the counter direction state.
package pwm_bank_pkg;

  localparam logic [6:0] ADDR_OUT_EN_LO = 7'h00;
  localparam logic [6:0] ADDR_OUT_EN_HI = 7'h01;
  localparam logic [6:0] ADDR_PWM_EN_LO = 7'h02;
  localparam logic [6:0] ADDR_PWM_EN_HI = 7'h03;
  localparam logic [6:0] ADDR_PRESCALE  = 7'h04;
  localparam logic [6:0] ADDR_MODE      = 7'h05;
  localparam logic [6:0] ADDR_DUTY_BASE = 7'h10;

  localparam int MODE_CENTER_BIT = 0;
  localparam int MODE_RUN_BIT    = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } dir_state_e;

endpackage

// File: rtl/pwm_bank_ctrl_timebase.sv
// Shared PWM timebase: prescaler, edge/center counter and period_start pulse.
//
//   state | meaning
//   IDLE  | run=0, counter held at 0
//   UP    | counting up (edge mode stays here, wrapping at MAX-1)
//   DOWN  | center mode, counting down from MAX-2 to 0
module pwm_timebase
  import pwm_bank_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PRE_W-1:0] prescale,
  input  logic             prescale_wr,
  input  logic             run,
  input  logic             center,
  input  logic             mode_wr,
  output logic [CNT_W-1:0] cnt,
  output logic             tick,
  output logic             period_start
);

  localparam logic [CNT_W-1:0] CNT_TOP = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dir_state_e       state_q, state_d;
  logic             pstart_q, pstart_d;

  assign tick         = (pre_q == prescale);
  assign cnt          = cnt_q;
  assign period_start = pstart_q;

  always_comb begin
    pre_d    = (prescale_wr || tick) ? '0 : pre_q + 1'b1;
    cnt_d    = cnt_q;
    state_d  = state_q;
    // A mode write restarts the period, so the tick it coincides with is not a start
    pstart_d = run && tick && (cnt_q == '0) && !mode_wr;

    if (!run) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (mode_wr) begin
      state_d = UP;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, UP: begin
          state_d = UP;
          if (tick) begin
            if (cnt_q == CNT_TOP) begin
              if (center) begin
                cnt_d   = cnt_q - 1'b1;
                state_d = DOWN;
              end else begin
                cnt_d = '0;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        DOWN: begin
          if (tick) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_ONE) state_d = UP;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q    <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      pstart_q <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      pstart_q <= pstart_d;
    end
  end

endmodule

// File: rtl/pwm_bank_ctrl.sv
// Multi-channel PWM bank: register file, shadow/active duties and per-channel
// compare, driven by the shared pwm_timebase.
module pwm_bank_ctrl
  import pwm_bank_pkg::*;
#(
  parameter int NUM_CH = 16,
  parameter int CNT_W  = 8,
  parameter int PRE_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [6:0]        wr_addr,
  input  logic [7:0]        wr_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_start
);

  logic [15:0]       out_en_q, out_en_d;
  logic [15:0]       pwm_en_q, pwm_en_d;
  logic [PRE_W-1:0]  prescale_q, prescale_d;
  logic [1:0]        mode_q, mode_d;
  logic [CNT_W-1:0]  shadow_q [NUM_CH];
  logic [CNT_W-1:0]  shadow_d [NUM_CH];
  logic [CNT_W-1:0]  active_q [NUM_CH];
  logic [CNT_W-1:0]  active_d [NUM_CH];
  logic [NUM_CH-1:0] pwm_out_q, pwm_out_d;

  logic             mode_wr, prescale_wr, duty_wr;
  logic [3:0]       duty_ch;
  logic             run, copy, tick;
  logic [CNT_W-1:0] cnt;

  assign run         = mode_q[MODE_RUN_BIT];
  assign mode_wr     = wr_en && (wr_addr == ADDR_MODE);
  assign prescale_wr = wr_en && (wr_addr == ADDR_PRESCALE);
  assign duty_wr     = wr_en && (wr_addr[6:4] == ADDR_DUTY_BASE[6:4]);
  assign duty_ch     = wr_addr[3:0];
  // Active duties follow the shadows while stopped and reload at each period start
  assign copy        = !run || (tick && (cnt == '0) && !mode_wr);

  pwm_timebase #(
    .CNT_W (CNT_W),
    .PRE_W (PRE_W)
  ) u_timebase (
    .clk          (clk),
    .rst          (rst),
    .prescale     (prescale_q),
    .prescale_wr  (prescale_wr),
    .run          (run),
    .center       (mode_q[MODE_CENTER_BIT]),
    .mode_wr      (mode_wr),
    .cnt          (cnt),
    .tick         (tick),
    .period_start (period_start)
  );

  always_comb begin
    out_en_d   = out_en_q;
    pwm_en_d   = pwm_en_q;
    prescale_d = prescale_q;
    mode_d     = mode_q;
    if (wr_en) begin
      case (wr_addr)
        ADDR_OUT_EN_LO: out_en_d[7:0]  = wr_data;
        ADDR_OUT_EN_HI: out_en_d[15:8] = wr_data;
        ADDR_PWM_EN_LO: pwm_en_d[7:0]  = wr_data;
        ADDR_PWM_EN_HI: pwm_en_d[15:8] = wr_data;
        ADDR_PRESCALE:  prescale_d     = PRE_W'(wr_data);
        ADDR_MODE:      mode_d         = wr_data[1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    pwm_out_d = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      shadow_d[ch] = shadow_q[ch];
      active_d[ch] = copy ? shadow_q[ch] : active_q[ch];
      if (duty_wr && (int'(duty_ch) == ch)) begin
        shadow_d[ch] = wr_data[CNT_W-1:0];
        if (copy) active_d[ch] = wr_data[CNT_W-1:0];
      end

      if (!out_en_q[ch])      pwm_out_d[ch] = 1'b0;
      else if (!pwm_en_q[ch]) pwm_out_d[ch] = 1'b1;
      else if (!run)          pwm_out_d[ch] = 1'b0;
      else                    pwm_out_d[ch] = (cnt < active_q[ch]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_en_q   <= '0;
      pwm_en_q   <= '0;
      prescale_q <= '0;
      mode_q     <= '0;
      pwm_out_q  <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        shadow_q[ch] <= '0;
        active_q[ch] <= '0;
      end
    end else begin
      out_en_q   <= out_en_d;
      pwm_en_q   <= pwm_en_d;
      prescale_q <= prescale_d;
      mode_q     <= mode_d;
      pwm_out_q  <= pwm_out_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
    end
  end

  assign pwm_out = pwm_out_q;

endmodule

// File: tb/tb_pwm_bank_ctrl.sv
// Self-checking bench for pwm_bank_ctrl: register vector table, directed
// waveform measurements, and random writes against a period-phase model.
module tb_pwm_bank_ctrl;

  localparam int NUM_CH = 16;
  localparam int MAX    = 255;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [6:0]        wr_addr = '0;
  logic [7:0]        wr_data = '0;
  logic [NUM_CH-1:0] pwm_out;
  logic              period_start;

  always #5 clk = ~clk;

  pwm_bank_ctrl #(.NUM_CH(NUM_CH), .CNT_W(8), .PRE_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: position within the period is a plain phase counter
  int m_out_en, m_pwm_en, m_prescale, m_mode, m_pre, m_phase;
  int m_shadow [NUM_CH];
  int m_active [NUM_CH];
  logic [NUM_CH-1:0] exp_out;
  logic              exp_ps;

  task automatic model_step();
    int run, center, per, cnt, tck, mwr, pst, cpy, dch;
    if (rst) begin
      m_out_en = 0; m_pwm_en = 0; m_prescale = 0; m_mode = 0; m_pre = 0; m_phase = 0;
      for (int c = 0; c < NUM_CH; c++) begin m_shadow[c] = 0; m_active[c] = 0; end
      exp_out = '0; exp_ps = 1'b0;
      return;
    end
    run    = (m_mode >> 1) & 1;
    center = m_mode & 1;
    per    = center ? 2*MAX-2 : MAX;
    cnt    = (m_phase < MAX) ? m_phase : 2*MAX-2-m_phase;
    tck    = (m_pre == m_prescale) ? 1 : 0;
    mwr    = (wr_en && wr_addr == 7'h05) ? 1 : 0;
    pst    = (run != 0 && tck != 0 && cnt == 0 && mwr == 0) ? 1 : 0;
    cpy    = (pst != 0 || run == 0) ? 1 : 0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!m_out_en[c])      exp_out[c] = 1'b0;
      else if (!m_pwm_en[c]) exp_out[c] = 1'b1;
      else if (run == 0)     exp_out[c] = 1'b0;
      else                   exp_out[c] = (cnt < m_active[c]);
    end
    exp_ps = (pst != 0);
    if (cpy != 0) for (int c = 0; c < NUM_CH; c++) m_active[c] = m_shadow[c];
    if (wr_en && wr_addr >= 16 && wr_addr < 16 + NUM_CH) begin
      dch = int'(wr_addr) - 16;
      m_shadow[dch] = int'(wr_data);
      if (cpy != 0) m_active[dch] = int'(wr_data);
    end
    m_pre   = ((wr_en && wr_addr == 7'h04) || tck != 0) ? 0 : m_pre + 1;
    m_phase = (run == 0 || mwr != 0) ? 0 : (tck != 0) ? (m_phase + 1) % per : m_phase;
    if (wr_en) begin
      case (wr_addr)
        7'h00: m_out_en = (m_out_en & 32'hFF00) | int'(wr_data);
        7'h01: m_out_en = (m_out_en & 32'h00FF) | (int'(wr_data) << 8);
        7'h02: m_pwm_en = (m_pwm_en & 32'hFF00) | int'(wr_data);
        7'h03: m_pwm_en = (m_pwm_en & 32'h00FF) | (int'(wr_data) << 8);
        7'h04: m_prescale = int'(wr_data);
        7'h05: m_mode = int'(wr_data) & 3;
        default: ;
      endcase
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick_clk();
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick_clk();
    tick_clk();
    rst = 1'b0;
  endtask

  task automatic wait_ps(input int budget);
    int n = 0;
    while (period_start !== 1'b1 && n < budget) begin
      tick_clk();
      n++;
    end
    check("wait_period_start", period_start, 1);
  endtask

  // Samples n cycles starting with the current one, optionally issuing a write
  task automatic measure(input int n, input int ch, input int wr_at,
                         input logic [6:0] wa, input logic [7:0] wd,
                         output int hi, output int ps_cnt,
                         output int first_low, output int last_low);
    hi = 0; ps_cnt = 0; first_low = -1; last_low = -1;
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick_clk();
      wr_en = 1'b0;
      if (pwm_out[ch]) hi++;
      else begin
        if (first_low < 0) first_low = i;
        last_low = i;
      end
      if (period_start) ps_cnt++;
      if (i == wr_at) begin wr_en = 1'b1; wr_addr = wa; wr_data = wd; end
    end
    tick_clk();
    wr_en = 1'b0;
  endtask

  typedef struct {
    logic        r;
    logic        we;
    logic [6:0]  a;
    logic [7:0]  d;
    logic [15:0] eo;
    logic        eps;
  } vec_t;

  vec_t tbl [20];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, psc, fl, ll, sel;
    logic [6:0] addr_sel [6];

    tbl[0]  = '{1'b1, 1'b0, 7'h00, 8'h00, 16'h0000, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 7'h00, 8'hFF, 16'h0000, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 7'h00, 8'h01, 16'h0000, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 7'h00, 8'h00, 16'h0001, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 7'h01, 8'h80, 16'h0001, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 7'h00, 8'h00, 16'h8001, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 7'h02, 8'h01, 16'h8001, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 7'h00, 8'h00, 16'h8000, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 7'h7F, 8'hFF, 16'h8000, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 7'h20, 8'hFF, 16'h8000, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 7'h03, 8'h80, 16'h8000, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 7'h00, 8'h00, 16'h0000, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 7'h00, 8'h00, 16'h0000, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 7'h01, 8'h00, 16'h0000, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 7'h00, 8'hFF, 16'h0000, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 7'h00, 8'h00, 16'h0000, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 7'h00, 8'h00, 16'h0000, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 7'h05, 8'h02, 16'h0000, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 7'h00, 8'h00, 16'h0000, 1'b1};
    tbl[19] = '{1'b0, 1'b0, 7'h00, 8'h00, 16'h0000, 1'b0};

    for (int i = 0; i < 20; i++) begin
      rst = tbl[i].r; wr_en = tbl[i].we; wr_addr = tbl[i].a; wr_data = tbl[i].d;
      tick_clk();
      check($sformatf("vec%0d_out", i), pwm_out, tbl[i].eo);
      check($sformatf("vec%0d_ps", i), period_start, tbl[i].eps);
    end
    rst = 1'b0; wr_en = 1'b0;

    // Edge-aligned PWM, duty 0x80 on ch1 and 0x00 on ch2
    do_reset();
    wr(7'h00, 8'h06); wr(7'h02, 8'h06); wr(7'h11, 8'h80); wr(7'h12, 8'h00);
    wr(7'h04, 8'h00); wr(7'h05, 8'h02);
    wait_ps(600);
    measure(255, 1, -1, 7'h00, 8'h00, hi, psc, fl, ll);
    check("edge_hi_ch1", hi, 128);
    check("edge_ps_in_period", psc, 1);
    check("edge_period_255", period_start, 1);
    measure(255, 2, -1, 7'h00, 8'h00, hi, psc, fl, ll);
    check("duty0_hi_ch2", hi, 0);

    // Full duty across three periods
    wr(7'h12, 8'hFF);
    wait_ps(600); tick_clk(); wait_ps(600);
    measure(765, 2, -1, 7'h00, 8'h00, hi, psc, fl, ll);
    check("dutymax_hi_ch2", hi, 765);
    check("dutymax_ps_cnt", psc, 3);

    // Shadowed duty update mid-period
    wr(7'h11, 8'h40);
    wait_ps(600); tick_clk(); wait_ps(600);
    measure(255, 1, 10, 7'h11, 8'hC0, hi, psc, fl, ll);
    check("shadow_cur_hi", hi, 64);
    measure(255, 1, -1, 7'h00, 8'h00, hi, psc, fl, ll);
    check("shadow_next_hi", hi, 192);

    // Center-aligned PWM with prescale 3
    do_reset();
    wr(7'h00, 8'h01); wr(7'h02, 8'h01); wr(7'h10, 8'h40); wr(7'h04, 8'h03); wr(7'h05, 8'h03);
    wait_ps(3000); tick_clk(); wait_ps(3000);
    measure(2032, 0, -1, 7'h00, 8'h00, hi, psc, fl, ll);
    check("center_hi", hi, 508);
    check("center_ps_cnt", psc, 1);
    check("center_period_2032", period_start, 1);
    check("center_first_low", fl, 253);
    check("center_symmetry", fl + ll, 2029);
    check("center_high_before_rst", pwm_out[0], 1);
    rst = 1'b1;
    tick_clk();
    check("midperiod_rst_out", pwm_out, 0);
    check("midperiod_rst_ps", period_start, 0);
    rst = 1'b0;

    // Random register traffic against the reference model
    addr_sel[0] = 7'h00; addr_sel[1] = 7'h01; addr_sel[2] = 7'h02;
    addr_sel[3] = 7'h03; addr_sel[4] = 7'h04; addr_sel[5] = 7'h05;
    do_reset();
    wr(7'h05, 8'h02);
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      wr_en = 1'b0;
      if ($urandom_range(0, 9) == 0) begin
        wr_en = 1'b1;
        sel = $urandom_range(0, 19);
        wr_data = 8'($urandom);
        if (sel < 4) wr_addr = addr_sel[sel];
        else if (sel == 4) begin wr_addr = addr_sel[4]; wr_data = wr_data & 8'h03; end
        else if (sel == 5) begin
          wr_addr = addr_sel[5];
          wr_data = {6'd0, ($urandom_range(0, 5) != 0), wr_data[0]};
        end
        else if (sel == 6) wr_addr = 7'h7E;
        else wr_addr = 7'(16 + $urandom_range(0, 17));
      end
      tick_clk();
      check("rand_pwm_out", pwm_out, exp_out);
      check("rand_period_start", period_start, exp_ps);
    end
    rst = 1'b0; wr_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
